// File: rtl/rtc_pkg.sv
// Shared time-of-day types and field arithmetic for the RTC timekeeper.
package rtc_pkg;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HR_W   = 5;
  localparam int unsigned TIME_W = 17;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } time_t;

  typedef struct packed {
    logic  wrap;
    time_t t;
  } time_inc_t;

  function automatic logic time_valid(time_t t, int unsigned hours_wrap);
    return (32'(t.sec) < 32'd60) && (32'(t.min) < 32'd60) && (32'(t.hr) < hours_wrap);
  endfunction

  // Each field is tested at its limit before incrementing, so no field ever reaches 60 or hours_wrap.
  function automatic time_inc_t time_inc(time_t t, int unsigned hours_wrap);
    time_inc_t r;
    r.t    = t;
    r.wrap = 1'b0;
    if (t.sec == SEC_W'(59)) begin
      r.t.sec = '0;
      if (t.min == MIN_W'(59)) begin
        r.t.min = '0;
        if (32'(t.hr) == hours_wrap - 32'd1) begin
          r.t.hr = '0;
          r.wrap = 1'b1;
        end else begin
          r.t.hr = t.hr + HR_W'(1);
        end
      end else begin
        r.t.min = t.min + MIN_W'(1);
      end
    end else begin
      r.t.sec = t.sec + SEC_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_timekeeper_prescaler.sv
// Divides the system clock down to a one-second tick condition.
module rtc_prescaler #(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned DIV_W   = $clog2(CLK_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;

  // Left combinational so the top can register all effects of a tick on the same edge.
  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day keeper: hh:mm:ss counter with software set, alarm compare and day rollover pulse.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter int unsigned HOURS_WRAP = 24,
  parameter int unsigned DIV_W      = $clog2(CLK_DIV)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [TIME_W-1:0] load_time,
  input  logic              alarm_set,
  input  logic [TIME_W-1:0] alarm_time,
  input  logic              alarm_en,
  output logic [TIME_W-1:0] time_out,
  output logic              sec_tick,
  output logic              day_wrap,
  output logic              alarm_hit,
  output logic              load_err
);

  time_t     cur_q;
  time_t     alarm_q;
  time_t     load_t;
  time_t     alarm_t;
  time_inc_t nxt;
  logic      tick;
  logic      load_ok;
  logic      load_bad;
  logic      alarm_ok;
  logic      alarm_bad;
  logic      advance;
  logic      hit_pend_q;

  assign load_t  = load_time;
  assign alarm_t = alarm_time;

  assign load_ok   = load && time_valid(load_t, HOURS_WRAP);
  assign load_bad  = load && !time_valid(load_t, HOURS_WRAP);
  assign alarm_ok  = alarm_set && time_valid(alarm_t, HOURS_WRAP);
  assign alarm_bad = alarm_set && !time_valid(alarm_t, HOURS_WRAP);

  // A valid load swallows a coincident tick entirely.
  assign advance = tick && !load_ok;
  assign nxt     = time_inc(cur_q, HOURS_WRAP);

  rtc_prescaler #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (load_ok),
    .tick   (tick)
  );

  // Alarm compares the pre-update alarm register; the hit is staged one cycle behind sec_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q      <= '0;
      alarm_q    <= '0;
      sec_tick   <= 1'b0;
      day_wrap   <= 1'b0;
      hit_pend_q <= 1'b0;
      alarm_hit  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      sec_tick   <= advance;
      day_wrap   <= advance && nxt.wrap;
      hit_pend_q <= advance && alarm_en && (nxt.t == alarm_q);
      alarm_hit  <= hit_pend_q;
      load_err   <= load_bad || alarm_bad;
      if (load_ok) begin
        cur_q <= load_t;
      end else if (advance) begin
        cur_q <= nxt.t;
      end
      if (alarm_ok) begin
        alarm_q <= alarm_t;
      end
    end
  end

  assign time_out = cur_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper: directed tables and sequences plus random stimulus vs a seconds-of-day model.
module tb_rtc_timekeeper;

  localparam int CLK_DIV = 4;
  localparam int DAY     = 24 * 3600;

  logic        clk = 1'b0;
  logic        reset, enable, load, alarm_set, alarm_en;
  logic [16:0] load_time, alarm_time;
  logic [16:0] time_out;
  logic        sec_tick, day_wrap, alarm_hit, load_err;

  logic        load12;
  logic [16:0] load_time12;
  logic [16:0] time_out12;
  logic        sec_tick12, day_wrap12, alarm_hit12, load_err12;

  int n_checks = 0;
  int n_err    = 0;
  int n;

  // Reference model state: time as seconds since midnight.
  int m_secs, m_pre, m_alarm;
  bit m_pend;
  bit e_tick, e_wrap, e_hit, e_err;

  typedef struct {
    logic [16:0] val;
    bit          err;
    logic [16:0] t_after;
  } ld_vec_t;

  ld_vec_t ld_tab[7];

  always #5 clk = ~clk;

  rtc_timekeeper #(.CLK_DIV(CLK_DIV), .HOURS_WRAP(24)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_time  (load_time),
    .alarm_set  (alarm_set),
    .alarm_time (alarm_time),
    .alarm_en   (alarm_en),
    .time_out   (time_out),
    .sec_tick   (sec_tick),
    .day_wrap   (day_wrap),
    .alarm_hit  (alarm_hit),
    .load_err   (load_err)
  );

  rtc_timekeeper #(.CLK_DIV(CLK_DIV), .HOURS_WRAP(12)) u_dut12 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load12),
    .load_time  (load_time12),
    .alarm_set  (1'b0),
    .alarm_time (17'd0),
    .alarm_en   (1'b0),
    .time_out   (time_out12),
    .sec_tick   (sec_tick12),
    .day_wrap   (day_wrap12),
    .alarm_hit  (alarm_hit12),
    .load_err   (load_err12)
  );

  function automatic logic [16:0] hms(int h, int m, int s);
    logic [16:0] r;
    r = {5'(h), 6'(m), 6'(s)};
    return r;
  endfunction

  function automatic bit vld(logic [16:0] v);
    return (v[16:12] < 5'd24) && (v[11:6] < 6'd60) && (v[5:0] < 6'd60);
  endfunction

  function automatic int to_secs(logic [16:0] v);
    return int'(v[16:12]) * 3600 + int'(v[11:6]) * 60 + int'(v[5:0]);
  endfunction

  function automatic logic [16:0] to_hms(int s);
    return hms(s / 3600, (s / 60) % 60, s % 60);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Applies the inputs sampled at this edge to the behavioural model.
  task automatic model_step();
    bit tk, lv, av;
    e_hit  = 1'b0;
    e_tick = 1'b0;
    e_wrap = 1'b0;
    e_err  = 1'b0;
    if (reset) begin
      m_secs  = 0;
      m_pre   = 0;
      m_alarm = 0;
      m_pend  = 1'b0;
    end else begin
      tk     = enable && (m_pre == CLK_DIV - 1);
      lv     = vld(load_time);
      av     = vld(alarm_time);
      e_hit  = m_pend;
      m_pend = 1'b0;
      if (enable) m_pre = tk ? 0 : m_pre + 1;
      if (load && lv) begin
        m_secs = to_secs(load_time);
        m_pre  = 0;
      end else if (tk) begin
        m_secs = (m_secs + 1) % DAY;
        e_tick = 1'b1;
        e_wrap = (m_secs == 0);
        m_pend = alarm_en && (m_secs == m_alarm);
      end
      if (alarm_set && av) m_alarm = to_secs(alarm_time);
      e_err = (load && !lv) || (alarm_set && !av);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("time_out", 32'(time_out), 32'(to_hms(m_secs)));
    chk("sec_tick", 32'(sec_tick), 32'(e_tick));
    chk("day_wrap", 32'(day_wrap), 32'(e_wrap));
    chk("alarm_hit", 32'(alarm_hit), 32'(e_hit));
    chk("load_err", 32'(load_err), 32'(e_err));
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (!sec_tick && cnt < 64);
  endtask

  initial begin
    ld_tab[0] = '{hms(23, 59, 58), 1'b0, hms(23, 59, 58)};
    ld_tab[1] = '{hms(10, 60, 0),  1'b1, hms(5, 5, 5)};
    ld_tab[2] = '{hms(24, 0, 0),   1'b1, hms(5, 5, 5)};
    ld_tab[3] = '{hms(0, 0, 60),   1'b1, hms(5, 5, 5)};
    ld_tab[4] = '{hms(0, 0, 0),    1'b0, hms(0, 0, 0)};
    ld_tab[5] = '{hms(23, 59, 59), 1'b0, hms(23, 59, 59)};
    ld_tab[6] = '{hms(31, 63, 63), 1'b1, hms(5, 5, 5)};

    reset = 1'b1; enable = 1'b1; load = 1'b0; alarm_set = 1'b0; alarm_en = 1'b0;
    load_time = '0; alarm_time = '0; load12 = 1'b0; load_time12 = '0;
    cycle();
    cycle();
    chk("reset_time", 32'(time_out), 32'd0);
    chk("reset_time12", 32'(time_out12), 32'd0);
    reset = 1'b0;

    // First tick latency and steady tick period after reset release.
    wait_tick(n);
    chk("first_tick_latency", 32'(n), 32'(CLK_DIV));
    chk("time_after_first_tick", 32'(time_out), 32'(hms(0, 0, 1)));
    for (int i = 0; i < 59; i++) begin
      wait_tick(n);
      chk("tick_period", 32'(n), 32'(CLK_DIV));
    end
    chk("time_after_60_ticks", 32'(time_out), 32'(hms(0, 1, 0)));

    // Day rollover on both the 24 h and 12 h instances.
    load = 1'b1; load_time = hms(23, 59, 58);
    load12 = 1'b1; load_time12 = hms(11, 59, 58);
    cycle();
    load = 1'b0; load12 = 1'b0;
    chk("load_valid_time", 32'(time_out), 32'(hms(23, 59, 58)));
    wait_tick(n);
    chk("tick_after_load", 32'(n), 32'(CLK_DIV));
    chk("pre_wrap_time", 32'(time_out), 32'(hms(23, 59, 59)));
    chk("pre_wrap_time12", 32'(time_out12), 32'(hms(11, 59, 59)));
    wait_tick(n);
    chk("wrap_time", 32'(time_out), 32'd0);
    chk("wrap_pulse", 32'(day_wrap), 32'd1);
    chk("wrap_time12", 32'(time_out12), 32'd0);
    chk("wrap_pulse12", 32'({sec_tick12, day_wrap12}), 32'd3);

    // Load on the cycle a tick is due wins, and restarts the prescaler.
    repeat (CLK_DIV - 1) cycle();
    load = 1'b1; load_time = hms(12, 34, 56);
    cycle();
    load = 1'b0;
    chk("load_on_tick_time", 32'(time_out), 32'(hms(12, 34, 56)));
    chk("load_on_tick_no_tick", 32'(sec_tick), 32'd0);
    wait_tick(n);
    chk("load_on_tick_restart", 32'(n), 32'(CLK_DIV));
    chk("load_on_tick_next", 32'(time_out), 32'(hms(12, 34, 57)));

    // Load validity table, applied with timekeeping held.
    enable = 1'b0;
    foreach (ld_tab[i]) begin
      load = 1'b1; load_time = hms(5, 5, 5);
      cycle();
      load_time = ld_tab[i].val;
      cycle();
      load = 1'b0;
      chk("tab_load_err", 32'(load_err), 32'(ld_tab[i].err));
      chk("tab_time", 32'(time_out), 32'(ld_tab[i].t_after));
      cycle();
      chk("tab_err_single_cycle", 32'(load_err), 32'd0);
    end

    // Invalid load and invalid alarm together give one pulse.
    load = 1'b1; load_time = hms(10, 60, 0);
    alarm_set = 1'b1; alarm_time = hms(24, 0, 0);
    cycle();
    load = 1'b0; alarm_set = 1'b0;
    chk("dual_err_pulse", 32'(load_err), 32'd1);
    cycle();
    chk("dual_err_single", 32'(load_err), 32'd0);

    // Alarm at 00:00:05.
    enable = 1'b1; alarm_en = 1'b1;
    load = 1'b1; load_time = '0; alarm_set = 1'b1; alarm_time = hms(0, 0, 5);
    cycle();
    load = 1'b0; alarm_set = 1'b0;
    repeat (5) wait_tick(n);
    chk("alarm_time_reached", 32'(time_out), 32'(hms(0, 0, 5)));
    chk("alarm_not_in_tick_cycle", 32'(alarm_hit), 32'd0);
    cycle();
    chk("alarm_hit", 32'(alarm_hit), 32'd1);
    cycle();
    chk("alarm_hit_single", 32'(alarm_hit), 32'd0);

    alarm_set = 1'b1; alarm_time = hms(24, 0, 0);
    cycle();
    alarm_set = 1'b0;
    chk("alarm_invalid_err", 32'(load_err), 32'd1);

    alarm_en = 1'b0; load = 1'b1; load_time = '0;
    cycle();
    load = 1'b0;
    repeat (5) wait_tick(n);
    cycle();
    chk("alarm_disabled", 32'(alarm_hit), 32'd0);

    alarm_en = 1'b1; load = 1'b1; load_time = '0;
    cycle();
    load = 1'b0;
    repeat (5) wait_tick(n);
    cycle();
    chk("alarm_kept_after_bad_set", 32'(alarm_hit), 32'd1);

    load = 1'b1; load_time = hms(0, 0, 5);
    cycle();
    load = 1'b0;
    repeat (CLK_DIV + 2) begin
      cycle();
      chk("alarm_not_on_load", 32'(alarm_hit), 32'd0);
    end

    // Enable low freezes time and prescaler.
    wait_tick(n);
    cycle();
    cycle();
    begin
      logic [16:0] frozen;
      frozen = time_out;
      enable = 1'b0;
      repeat (10) cycle();
      chk("frozen_time", 32'(time_out), 32'(frozen));
    end
    enable = 1'b1;
    wait_tick(n);
    chk("resume_remaining", 32'(n), 32'(CLK_DIV - 2));

    // Reset mid-count.
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mid_reset_time", 32'(time_out), 32'd0);
    wait_tick(n);
    chk("mid_reset_first_tick", 32'(n), 32'(CLK_DIV));

    // Random stimulus against the model.
    for (int c = 0; c < 2500; c++) begin
      reset    = ($urandom_range(0, 599) == 0);
      enable   = ($urandom_range(0, 7) != 0);
      alarm_en = ($urandom_range(0, 5) != 0);
      load     = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       load_time = to_hms(DAY - 1 - int'($urandom_range(0, 3)));
        1:       load_time = to_hms(int'($urandom_range(0, DAY - 1)));
        default: load_time = 17'($urandom);
      endcase
      alarm_set = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) alarm_time = 17'($urandom);
      else alarm_time = to_hms((m_secs + int'($urandom_range(1, 6))) % DAY);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
